oem_byte_mapper: RTL
====================

Name: oem_byte_mapper

Overview:
- Downstream neighbour of the serial transmitter. Consumes the `so_data`/`so_valid` bit stream and packs it into bytes.
- Writes each byte into one of eight 32x8 output memories: odd1..4 and even1..4.
- Memory selection follows a checkerboard pattern over a 256-byte image of 4 groups x 8 rows x 8 columns.
- On `pi_end` it pads the unwritten locations with a fill value, then raises `oem_finish`.

Parameters:
- FILL_VALUE, 8'h00, byte written to every location not covered by stream data.
- MSB_FIRST, 1, 1 = first received bit is byte bit 7; 0 = first received bit is byte bit 0.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- so_data  input  1  serial data bit, valid when so_valid=1.
- so_valid  input  1  qualifies so_data; frames are 8/16/24/32 bits long.
- pi_end  input  1  one-cycle pulse: no more frames will follow.
- oem_dataout  output  8  byte to write.
- oem_addr  output  5  address inside the selected memory.
- odd1_wr, odd2_wr, odd3_wr, odd4_wr  output  1 each  write strobes for the odd memories.
- even1_wr, even2_wr, even3_wr, even4_wr  output  1 each  write strobes for the even memories.
- oem_finish  output  1  one-cycle pulse after the final (256th) write.

Behaviour:
- Clock and reset: one clock, `clk`; `reset` is synchronous and active-high.
- Reset values: all outputs 0. Bit counter, byte counter n (8 bits), shift register and end_pending are cleared; state = RECV.
- State RECV:
  - Each cycle with so_valid=1, shift so_data into an 8-bit shift register and increment the 3-bit bit counter.
  - When the 8th bit is sampled in cycle t, at t+1: oem_dataout = assembled byte, oem_addr = n[5:1], and exactly one strobe is high for one cycle. Then n increments.
  - Strobe selection: group g = n[7:6] selects memory index g+1. The odd bank is used when (n[3] XOR n[0]) = 0, otherwise the even bank.
  - Outside write cycles, all strobes are 0. oem_dataout and oem_addr hold their last values.
  - If so_valid falls with the bit counter nonzero, the partial bits are discarded and the bit counter is cleared.
- pi_end:
  - Latched into end_pending in any cycle of RECV.
  - Once end_pending=1, so_valid=0 and no byte write is outstanding, go to FILL on the next cycle.
  - If pi_end arrives in the same cycle as a completing 8th bit, that byte is still written first.
- State FILL:
  - One write per cycle: data = FILL_VALUE, address and strobe derived from n as above, n increments.
  - After the write with n=255, go to DONE.
  - so_valid is ignored in FILL.
- Overflow: if n reaches 255 and is written during RECV before any pi_end, go to DONE directly.
- State DONE:
  - oem_finish is high for exactly the first cycle in DONE, then 0.
  - All strobes stay 0. Inputs are ignored until reset.
- Reset mid-operation: asserting reset in any state returns the block to the reset values on the next edge. Partial bytes are lost.
- Write rate: at most one byte per 8 valid cycles in RECV; one byte per cycle in FILL. No backpressure to the upstream stage.

Optional Feature:
- Macro: OEM_FILL_EN.
- Defined: FILL state as above; the memories are always fully written with 256 writes.
- Undefined:
  - FILL is removed. Once end_pending=1 and the last pending byte is written, go straight to DONE.
  - oem_finish pulses one cycle later.
  - Unwritten locations are left untouched; FILL_VALUE is unused.

Test Plan:
- Reset, then one 8-bit frame 8'hA5 MSB first -> one cycle after the 8th bit: odd1_wr=1, oem_addr=0, oem_dataout=8'hA5; all other strobes 0.
- Two consecutive 8-bit frames 8'h11, 8'h22 -> n=0 writes via odd1_wr at addr 0; n=1 writes via even1_wr at addr 0.
- Stream of 9 bytes, values 0..8 -> byte n=8 (row 1, col 0) writes via even1_wr at addr 4.
- 64 bytes, then pi_end with OEM_FILL_EN defined -> 192 consecutive FILL writes of 8'h00:
  - n=64 via odd2_wr at addr 0; final write n=255 via odd4_wr at addr 31;
  - oem_finish high for exactly 1 cycle, then no further strobes.
- 5 bits, so_valid drops, then a 16-bit frame 16'hBEEF -> only two writes (8'hBE, 8'hEF) at n=0,1; the partial 5 bits are discarded.
- Without OEM_FILL_EN: 3 bytes, then pi_end -> 3 writes, then oem_finish one cycle after the last write with no fill writes. Asserting reset during the 2nd byte of a repeat run clears every output to 0 and n to 0.

Source files
------------

// File: rtl/oem_byte_mapper.sv
// rtl/oem_byte_mapper.sv - packs the serial bit stream into bytes and scatters them over eight 32x8 memories (optional pad phase: OEM_FILL_EN)
module oem_byte_mapper #(
    parameter logic [7:0] FILL_VALUE = 8'h00,
    parameter bit         MSB_FIRST  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       so_data,
    input  logic       so_valid,
    input  logic       pi_end,
    output logic [7:0] oem_dataout,
    output logic [4:0] oem_addr,
    output logic       odd1_wr,
    output logic       odd2_wr,
    output logic       odd3_wr,
    output logic       odd4_wr,
    output logic       even1_wr,
    output logic       even2_wr,
    output logic       even3_wr,
    output logic       even4_wr,
    output logic       oem_finish
);

    typedef enum logic [1:0] {RECV, FILL, DONE} state_t;

    state_t      state, state_nx;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  n;
    logic        end_pending;
    logic        last_wr;
    logic [7:0]  wr;
    logic [7:0]  byte_nx;
    logic [7:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        byte_done;
    logic        fill_wr;
    logic        do_wr;

    assign {even4_wr, even3_wr, even2_wr, even1_wr,
            odd4_wr,  odd3_wr,  odd2_wr,  odd1_wr} = wr;

    always_comb begin
        byte_nx   = MSB_FIRST ? {shreg[6:0], so_data} : {so_data, shreg[7:1]};
        byte_done = (state == RECV) && so_valid && (bit_cnt == 3'd7) && !last_wr;
`ifdef OEM_FILL_EN
        fill_wr   = (state == FILL) && !last_wr;
`else
        fill_wr   = 1'b0;
`endif
        do_wr     = byte_done || fill_wr;
        wr_data   = fill_wr ? FILL_VALUE : byte_nx;
        // checkerboard: bank from row/column parity, memory index from the group
        wr_sel    = 8'd1 << {(n[3] ^ n[0]), n[7:6]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            RECV: begin
                if (last_wr) begin
                    state_nx = DONE;
                end else if (end_pending && !so_valid) begin
`ifdef OEM_FILL_EN
                    state_nx = FILL;
`else
                    state_nx = DONE;
`endif
                end
            end
            FILL: begin
                if (last_wr) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RECV;
            bit_cnt     <= 3'd0;
            shreg       <= 8'd0;
            n           <= 8'd0;
            end_pending <= 1'b0;
            last_wr     <= 1'b0;
            wr          <= 8'd0;
            oem_dataout <= 8'd0;
            oem_addr    <= 5'd0;
            oem_finish  <= 1'b0;
        end else begin
            state      <= state_nx;
            wr         <= do_wr ? wr_sel : 8'd0;
            oem_finish <= (state_nx == DONE) && (state != DONE);
            if (do_wr) begin
                oem_dataout <= wr_data;
                oem_addr    <= n[5:1];
                n           <= n + 8'd1;
                last_wr     <= (n == 8'd255);
            end
            if (state == RECV) begin
                if (so_valid) begin
                    shreg   <= byte_nx;
                    bit_cnt <= bit_cnt + 3'd1;
                end else begin
                    // a frame cut short leaves a stale partial byte; drop it
                    bit_cnt <= 3'd0;
                end
                if (pi_end) begin
                    end_pending <= 1'b1;
                end
            end
        end
    end

endmodule
